// File: rtl/fir_dec_ctl.sv
// fir_dec_ctl: decimating sequencer that loads DECIM samples into a shift-register FIR,
// starts a pass, and hands the captured result downstream on a valid/ready handshake.
module fir_dec_ctl #(
    parameter int DECIM = 4,
    parameter int NTAPS = 64,
    parameter int CBASE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] fir_din,
    output logic        fir_write,
    output logic        fir_start,
    input  logic [15:0] fir_dout,
    input  logic        fir_rdy,
    input  logic        fir_ovf,
    output logic [15:0] m_data,
    output logic        m_ovf,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        ovf_sticky,
    input  logic        ovf_clr
);
    typedef enum logic [2:0] {INIT, FILL, WR_LAST, START, WAIT, OUT} state_t;
    localparam logic [15:0] CMD  = {1'b0, 7'(NTAPS), 1'b0, 7'(CBASE)};
    localparam logic [3:0]  LAST = 4'(DECIM - 1);
    state_t     r_state;
    logic [3:0] r_cnt;
    assign s_ready = (r_state == FILL);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= INIT;
            r_cnt      <= '0;
            fir_din    <= '0;
            fir_write  <= 1'b0;
            fir_start  <= 1'b0;
            m_data     <= '0;
            m_ovf      <= 1'b0;
            m_valid    <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            fir_write <= 1'b0;
            fir_start <= 1'b0;
            // a capture in the same cycle overrides the clear below
            if (ovf_clr) ovf_sticky <= 1'b0;
            case (r_state)
                INIT: if (fir_rdy) r_state <= FILL;
                FILL: if (s_valid) begin
                    fir_write <= 1'b1;
                    fir_din   <= s_data;
                    r_cnt     <= (r_cnt == LAST) ? 4'd0 : r_cnt + 4'd1;
                    if (r_cnt == LAST) r_state <= WR_LAST;
                end
                WR_LAST: begin
                    fir_start <= 1'b1;
                    fir_din   <= CMD;
                    r_state   <= START;
                end
                START: r_state <= WAIT;
                WAIT: if (fir_rdy) begin
                    m_data  <= fir_dout;
                    m_ovf   <= fir_ovf;
                    m_valid <= 1'b1;
                    if (fir_ovf) ovf_sticky <= 1'b1;
                    r_state <= OUT;
                end
                OUT: if (m_ready) begin
                    m_valid <= 1'b0;
                    r_state <= FILL;
                end
                default: r_state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_dec_ctl.sv
// tb_fir_dec_ctl: directed and randomized checks of fir_dec_ctl against simple filter models
// (instance A: DECIM=4 NTAPS=64 CBASE=0, instance B: DECIM=1 NTAPS=1 CBASE=5).
module tb_fir_dec_ctl;
    localparam int NT_A = 64;
    logic clk = 0;
    logic rst = 0;
    always #5 clk = ~clk;
    int errs = 0;
    int checks = 0;
    bit hold = 1;

    logic [15:0] a_sdata = '0, a_din, a_dout = '0, a_mdata, a_next_dout = '0, a_cmd = '0;
    logic a_svalid = 0, a_sready, a_wr, a_st, a_rdy, a_ovf = 0, a_movf, a_mvalid;
    logic a_mready = 0, a_sticky, a_clr = 0, a_rdy_m = 1, a_next_ovf = 0;
    int a_cnt = 0, a_extra = 0, a_starts = 0, a_coinc = 0;
    logic [15:0] a_wq[$];
    assign a_rdy = a_rdy_m & ~hold;

    logic [15:0] b_sdata = '0, b_din, b_dout = '0, b_mdata, b_last = '0, b_cmd = '0;
    logic b_svalid = 0, b_sready, b_wr, b_st, b_rdy, b_ovf = 0, b_movf, b_mvalid;
    logic b_mready = 0, b_sticky, b_rdy_m = 1;
    int b_cnt = 0, b_starts = 0, b_coinc = 0, b_nwr = 0;
    assign b_rdy = b_rdy_m & ~hold;

    fir_dec_ctl #(.DECIM(4), .NTAPS(NT_A), .CBASE(0)) dut_a (
        .clk(clk), .rst(rst), .s_data(a_sdata), .s_valid(a_svalid), .s_ready(a_sready),
        .fir_din(a_din), .fir_write(a_wr), .fir_start(a_st), .fir_dout(a_dout),
        .fir_rdy(a_rdy), .fir_ovf(a_ovf), .m_data(a_mdata), .m_ovf(a_movf),
        .m_valid(a_mvalid), .m_ready(a_mready), .ovf_sticky(a_sticky), .ovf_clr(a_clr)
    );

    fir_dec_ctl #(.DECIM(1), .NTAPS(1), .CBASE(5)) dut_b (
        .clk(clk), .rst(rst), .s_data(b_sdata), .s_valid(b_svalid), .s_ready(b_sready),
        .fir_din(b_din), .fir_write(b_wr), .fir_start(b_st), .fir_dout(b_dout),
        .fir_rdy(b_rdy), .fir_ovf(b_ovf), .m_data(b_mdata), .m_ovf(b_movf),
        .m_valid(b_mvalid), .m_ready(b_mready), .ovf_sticky(b_sticky), .ovf_clr(1'b0)
    );

    // filter A: records writes, goes busy on start, returns rdy NTAPS+1+extra cycles later
    always @(posedge clk) begin
        if (a_wr) a_wq.push_back(a_din);
        if (a_wr && a_st) a_coinc <= a_coinc + 1;
        if (a_st) begin
            a_starts <= a_starts + 1;
            a_cmd    <= a_din;
            a_rdy_m  <= 0;
            a_cnt    <= NT_A + a_extra;
        end else if (a_cnt == 1) begin
            a_cnt   <= 0;
            a_rdy_m <= 1;
            a_dout  <= a_next_dout;
            a_ovf   <= a_next_ovf;
        end else if (a_cnt > 1) a_cnt <= a_cnt - 1;
    end

    // filter B: result is a fixed function of the last written sample
    always @(posedge clk) begin
        if (b_wr) begin
            b_last <= b_din;
            b_nwr  <= b_nwr + 1;
        end
        if (b_wr && b_st) b_coinc <= b_coinc + 1;
        if (b_st) begin
            b_starts <= b_starts + 1;
            b_cmd    <= b_din;
            b_rdy_m  <= 0;
            b_cnt    <= 1 + int'($urandom_range(0, 3));
        end else if (b_cnt == 1) begin
            b_cnt   <= 0;
            b_rdy_m <= 1;
            b_dout  <= b_last ^ 16'hA5A5;
            b_ovf   <= b_last[0];
        end else if (b_cnt > 1) b_cnt <= b_cnt - 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pass_a(input logic [15:0] dout, input logic ovf, input int extra,
                          input bit clr_mid, input bit seq, input logic exp_sticky);
        logic [15:0] sent[$];
        int k;
        bit early, noisy;
        early = 0;
        noisy = 0;
        a_next_dout = dout;
        a_next_ovf = ovf;
        a_extra = extra;
        a_wq.delete();
        for (int i = 0; i < 4; i++) begin
            a_svalid = 0;
            if (!seq) repeat ($urandom_range(0, 2)) begin early |= a_st; cyc(); end
            a_sdata = seq ? 16'(i + 1) : 16'($urandom);
            a_svalid = 1;
            k = 0;
            while (!a_sready && k < 50) begin early |= a_st; cyc(); k++; end
            chk("pass_sready", a_sready, 1);
            early |= a_st;
            sent.push_back(a_sdata);
            cyc();
        end
        a_svalid = 0;
        chk("pass_no_early_start", early, 0);
        chk("pass_last_write", a_wr, 1);
        chk("pass_sready_stall", a_sready, 0);
        cyc();
        chk("pass_start", a_st, 1);
        chk("pass_cmd", a_din, 16'h4000);
        chk("pass_no_wr_at_start", a_wr, 0);
        a_clr = clr_mid;
        k = 0;
        while (!a_mvalid && k < 300) begin
            cyc();
            k++;
            noisy |= a_wr | a_st | a_sready;
            if (clr_mid && k == 3) chk("pass_clr_mid", a_sticky, 0);
        end
        a_clr = 0;
        chk("pass_wait_quiet", noisy, 0);
        chk("pass_latency", k, NT_A + 2 + extra);
        chk("pass_mdata", a_mdata, dout);
        chk("pass_movf", a_movf, ovf);
        chk("pass_sticky", a_sticky, exp_sticky);
        chk("pass_nwrites", a_wq.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("pass_wdata", i < a_wq.size() ? a_wq[i] : 16'hxxxx, sent[i]);
    endtask

    initial begin
        int k, s0, acc, outs;
        bit hs, xf;
        logic [15:0] sq[$];
        logic [15:0] e;
        // reset and INIT hold-off
        repeat (3) cyc();
        chk("rst_sready", a_sready, 0);
        chk("rst_write", a_wr, 0);
        chk("rst_start", a_st, 0);
        chk("rst_din", a_din, 0);
        chk("rst_mdata", a_mdata, 0);
        chk("rst_movf", a_movf, 0);
        chk("rst_mvalid", a_mvalid, 0);
        chk("rst_sticky", a_sticky, 0);
        chk("rst_b_outs", {b_sready, b_wr, b_st, b_mvalid, b_sticky}, 0);
        rst = 1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("init_sready", a_sready, 0);
            chk("init_write", a_wr, 0);
        end
        hold = 0;
        cyc();
        chk("init_exit_sready", a_sready, 1);
        chk("init_exit_b_sready", b_sready, 1);
        // basic directed pass, then output backpressure
        a_mready = 0;
        pass_a(16'h1234, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("bp_mvalid", a_mvalid, 1);
            chk("bp_mdata", a_mdata, 16'h1234);
            chk("bp_quiet", a_sready | a_wr | a_st, 0);
        end
        a_mready = 1;
        cyc();
        chk("bp_release_mvalid", a_mvalid, 0);
        chk("bp_release_sready", a_sready, 1);
        // overflow capture, set-over-clear, lone clear
        pass_a(16'h7FFF, 1, int'($urandom_range(1, 6)), 0, 0, 1);
        cyc();
        chk("ovf_first_out_done", a_mvalid, 0);
        chk("ovf_back_to_fill", a_sready, 1);
        chk("ovf_sticky_held", a_sticky, 1);
        pass_a(16'($urandom), 1, int'($urandom_range(0, 6)), 1, 0, 1);
        cyc();
        a_clr = 1;
        cyc();
        a_clr = 0;
        chk("ovf_lone_clr", a_sticky, 0);
        pass_a(16'h5A5A, 0, 0, 0, 0, 0);
        cyc();
        // DECIM=1 with random input gaps and output stalls
        hs = 0;
        acc = 0;
        outs = 0;
        for (int c = 0; c < 500; c++) begin
            if (c >= 400) begin
                b_svalid = 0;
                b_mready = 1;
            end else begin
                if (!b_svalid || hs) begin
                    b_svalid = ($urandom_range(0, 2) == 0);
                    b_sdata = 16'($urandom);
                end
                b_mready = 1'($urandom_range(0, 1));
            end
            hs = b_svalid && b_sready;
            xf = b_mvalid && b_mready;
            if (hs) begin
                sq.push_back(b_sdata);
                acc++;
            end
            if (xf) begin
                outs++;
                chk("gap_have_sample", sq.size() > 0, 1);
                e = 16'h0;
                if (sq.size() > 0) e = sq.pop_front();
                chk("gap_mdata", b_mdata, e ^ 16'hA5A5);
                chk("gap_movf", b_movf, e[0]);
            end
            cyc();
        end
        chk("gap_outs", outs, acc);
        chk("gap_starts", b_starts, acc);
        chk("gap_writes", b_nwr, acc);
        chk("gap_coinc", a_coinc + b_coinc, 0);
        chk("gap_cmd", b_cmd, 16'h0105);
        // reset while the filter is computing
        for (int i = 0; i < 4; i++) begin
            a_svalid = 1;
            a_sdata = 16'(i + 16'h100);
            k = 0;
            while (!a_sready && k < 50) begin cyc(); k++; end
            cyc();
        end
        a_svalid = 0;
        repeat (3) cyc();
        chk("wait_busy", a_rdy, 0);
        hold = 1;
        rst = 0;
        #1;
        chk("mid_rst_sready", a_sready, 0);
        chk("mid_rst_write", a_wr, 0);
        chk("mid_rst_start", a_st, 0);
        chk("mid_rst_din", a_din, 0);
        chk("mid_rst_mdata", a_mdata, 0);
        chk("mid_rst_mvalid", a_mvalid, 0);
        chk("mid_rst_b_din", b_din, 0);
        cyc();
        rst = 1;
        s0 = a_starts;
        a_wq.delete();
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("post_rst_sready", a_sready, 0);
            chk("post_rst_write", a_wr, 0);
        end
        hold = 0;
        k = 0;
        while (!a_rdy && k < 200) begin cyc(); k++; end
        chk("post_rst_rdy_return", a_rdy, 1);
        cyc();
        chk("post_rst_fill", a_sready, 1);
        chk("post_rst_no_writes", a_wq.size(), 0);
        chk("post_rst_no_starts", a_starts, s0);
        // reset mid-fill discards the partial count
        for (int i = 0; i < 2; i++) begin
            a_svalid = 1;
            a_sdata = 16'(i + 16'h200);
            k = 0;
            while (!a_sready && k < 50) begin cyc(); k++; end
            cyc();
        end
        a_svalid = 0;
        rst = 0;
        cyc();
        rst = 1;
        cyc();
        chk("fill_rst_refill", a_sready, 1);
        pass_a(16'h0F0F, 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/fir_dec_ctl.md
Name: fir_dec_ctl

Overview:
- Decimating front-end sequencer that sits directly upstream of the shift-register FIR filter (16-bit data, 18-bit coefficients, 1-127 taps).
- Accepts a 16-bit input sample stream with a valid/ready handshake and writes each sample into the filter's data shift register.
- After every DECIM samples it issues a filter start command, waits for filter ready, then captures the rounded, saturated output and overflow flag.
- Presents the captured result downstream on a valid/ready handshake, so the filter produces one output per DECIM inputs.

Parameters:
DECIM, 4, decimation ratio: samples written per filter pass; legal range 1-16.
NTAPS, 64, tap count sent in the start command; legal range 1-127; 0 is illegal.
CBASE, 0, first coefficient address sent in the start command; range 0-127.

Ports:
clk  in  1  master clock
rst  in  1  asynchronous, active-low reset
s_data  in  16  input sample
s_valid  in  1  input sample valid
s_ready  out  1  controller accepts a sample this cycle
fir_din  out  16  filter din: sample on a write cycle, command word on a start cycle
fir_write  out  1  filter data-write strobe
fir_start  out  1  filter start strobe
fir_dout  in  16  filter rounded/saturated result
fir_rdy  in  1  filter calculations complete
fir_ovf  in  1  filter accumulator overflow
m_data  out  16  decimated output sample
m_ovf  out  1  overflow flag for m_data
m_valid  out  1  output valid
m_ready  in  1  downstream accepts the output
ovf_sticky  out  1  set by any captured overflow; cleared by ovf_clr
ovf_clr  in  1  synchronous clear of ovf_sticky

Behaviour:
- Reset (rst=0, asynchronous) clears everything:
  - All outputs are 0, including s_ready, fir_write, fir_start, m_valid, m_data, m_ovf, ovf_sticky and fir_din.
  - State goes to INIT and the sample counter goes to 0.
  - Reset mid-pass abandons the pass; any partially accumulated samples are discarded.
- All outputs are registered, except s_ready, which is decoded from state.
- States:
  - INIT: wait for fir_rdy=1, so the controller never writes into a filter that is still busy after reset. On fir_rdy=1, go to FILL.
  - FILL:
    - s_ready=1.
    - Sample accepted when s_valid & s_ready. The next cycle drives fir_write=1 and fir_din=s_data for exactly one cycle.
    - The counter increments on each accepted sample.
    - When the DECIM-th sample is accepted: the counter goes to 0 and state goes to WR_LAST.
  - WR_LAST: s_ready=0. The write of the last sample occurs this cycle; go to START.
  - START:
    - One cycle with fir_start=1 and fir_din={1'b0,NTAPS[6:0],1'b0,CBASE[6:0]}. fir_write=0.
    - Go to WAIT.
  - WAIT:
    - s_ready=0 and fir_write=0. The filter's data register must not shift while it computes.
    - fir_rdy is low from the first WAIT cycle because NTAPS≥1.
    - On the first cycle with fir_rdy=1: register m_data=fir_dout and m_ovf=fir_ovf, set m_valid=1, and go to OUT.
  - OUT:
    - m_valid is held with m_data stable until m_ready=1.
    - On m_valid & m_ready: m_valid goes to 0 the next cycle and state goes to FILL.
    - If m_ready is already high when m_valid rises, the transfer completes in that first OUT cycle.
- fir_write and fir_start are never high in the same cycle. fir_start is never high outside START.
- Latency:
  - From the handshake of the DECIM-th sample to fir_start = 2 cycles.
  - From fir_start to m_valid = NTAPS+2 cycles for a filter whose rdy returns NTAPS+1 cycles after start.
  - The controller must tolerate any longer rdy delay.
- Throughput: one output per DECIM + NTAPS + 4 + (OUT stall) cycles minimum. Inputs are stalled (s_ready=0) from WR_LAST through OUT.
- DECIM=1: every accepted sample goes FILL→WR_LAST→START→WAIT→OUT.
- ovf_sticky:
  - Set on the capture cycle when fir_ovf=1.
  - ovf_clr=1 clears it.
  - If set and clear occur in the same cycle, set wins.
- The counter is 4 bits and wraps at DECIM-1→0. It never exceeds DECIM-1.

Test Plan:
1. Reset/INIT: hold fir_rdy=0 for 10 cycles after rst release → s_ready=0, no fir_write. Raise fir_rdy → s_ready=1 on the next cycle.
2. Basic pass, DECIM=4, NTAPS=64, CBASE=0: feed samples 0x0001..0x0004 back-to-back → four fir_write pulses with matching fir_din. Then fir_start with fir_din=0x4000 two cycles after the 4th handshake. The filter model returns 0x1234 → m_data=0x1234, m_ovf=0.
3. Backpressure: hold m_ready=0 for 20 cycles after m_valid → m_data stable, s_ready=0, no writes or starts. Raise m_ready → the next cycle is FILL with s_ready=1.
4. Overflow: the model asserts fir_ovf with dout=0x7FFF → m_ovf=1, ovf_sticky=1. Pulse ovf_clr concurrently with a second overflow capture → ovf_sticky remains 1. A lone ovf_clr → ovf_sticky=0.
5. Gapped input with DECIM=1, NTAPS=1: random s_valid gaps → exactly one fir_start per accepted sample. fir_write and fir_start are never coincident. Outputs arrive in order.
6. Mid-WAIT reset: assert rst with fir_rdy=0 → all outputs 0 immediately. After release, with fir_rdy still 0, the controller stays in INIT. No write occurs until fir_rdy=1.
